// File: rtl/bluetooth_tx.sv
// bluetooth_tx: FIFO-buffered UART 8N1 transmitter feeding the Bluetooth module RX pin
module bluetooth_tx #(
  parameter int BPS_NUM = 10416,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       tx_done,
  output logic       out_msg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = BPS_NUM > 1 ? $clog2(BPS_NUM) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp, count;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic tick, push, pop;
  assign tick    = cnt == CW'(BPS_NUM - 1);
  assign full    = count == (AW+1)'(DEPTH);
  assign busy    = state != IDLE || count != '0;
  assign tx_done = state == STOP && tick;
  assign push    = wr_en && !full;
  // next state and FIFO pop; a pop loads the shift register and starts a frame
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = count != '0;
        state_n = pop ? START : IDLE;
      end
      START: state_n = tick ? DATA : START;
      DATA:  state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
      STOP: begin
        pop = tick && count != '0;
        state_n = !tick ? STOP : pop ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // FIFO storage, no reset needed since pointers gate validity
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wr_data;
  // FIFO pointers and occupancy; full comes from the registered count only
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // bit timing, shift register and registered serial line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      out_msg <= 1'b1;
    end else begin
      cnt <= (state == IDLE || tick || state_n != state) ? '0 : cnt + CW'(1);
      if (pop) begin
        sh <= mem[rp[AW-1:0]];
        bit_cnt <= '0;
        out_msg <= 1'b0;
      end else if (tick && state != STOP) begin
        out_msg <= (state == DATA && bit_cnt == 3'd7) ? 1'b1 : sh[0];
        sh <= sh >> 1;
        bit_cnt <= state == DATA ? bit_cnt + 3'd1 : 3'd0;
      end
    end
endmodule

// File: tb/tb_bluetooth_tx.sv
// tb_bluetooth_tx: randomized and directed checks of bluetooth_tx against a frame-level model
module tb_bluetooth_tx;
  localparam int BPS = 5;
  localparam int DEPTH = 4;
  localparam int F = 10 * BPS;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, busy, tx_done, out_msg;
  int checks = 0, errors = 0;
  int t = 0, fstart = -1;
  logic [7:0] fbyte = 8'h00;
  logic [7:0] q[$];
  logic cap = 1'b0;
  logic line_q[$];
  bluetooth_tx #(.BPS_NUM(BPS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .busy(busy), .tx_done(tx_done), .out_msg(out_msg)
  );
  always #5 clk = ~clk;
  // frame-level model: a pop starts a 10-bit frame when a frame slot is free
  task automatic model_edge(input logic we, input logic [7:0] d);
    logic was_full, can_pop;
    t++;
    if (!rst) begin
      q.delete();
      fstart = -1;
      return;
    end
    was_full = q.size() == DEPTH;
    can_pop = q.size() != 0 && (fstart < 0 || t >= fstart + F);
    if (can_pop) begin
      fbyte = q.pop_front();
      fstart = t;
    end
    if (we && !was_full) q.push_back(d);
  endtask
  task automatic check_outputs();
    logic active, e_out, e_done, e_busy, e_full;
    int k;
    active = fstart >= 0 && t < fstart + F;
    k = active ? (t - fstart) / BPS : 0;
    e_out = !active ? 1'b1 : k == 0 ? 1'b0 : k == 9 ? 1'b1 : fbyte[k-1];
    e_done = active && t == fstart + F - 1;
    e_busy = active || q.size() != 0;
    e_full = q.size() == DEPTH;
    checks++;
    assert (out_msg === e_out) else begin errors++; $error("FAIL out_msg t=%0d got %b exp %b", t, out_msg, e_out); end
    checks++;
    assert (tx_done === e_done) else begin errors++; $error("FAIL tx_done t=%0d got %b exp %b", t, tx_done, e_done); end
    checks++;
    assert (busy === e_busy) else begin errors++; $error("FAIL busy t=%0d got %b exp %b", t, busy, e_busy); end
    checks++;
    assert (full === e_full) else begin errors++; $error("FAIL full t=%0d got %b exp %b", t, full, e_full); end
    if (cap) line_q.push_back(out_msg);
  endtask
  task automatic step(input logic we, input logic [7:0] d);
    wr_en = we;
    wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    #1 check_outputs();
  endtask
  initial begin
    int s;
    logic [7:0] rx;
    for (int i = 0; i < 6; i++) step(i[0], 8'hFF);
    rst = 1'b1;
    step(1'b1, 8'h55);
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hA1 + 8'h11 * 8'(i));
    for (int i = 0; i < 4 * F + 20; i++) step(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (out_msg === 1'b1) else begin errors++; $error("FAIL rst_out got %b exp 1", out_msg); end
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy got %b exp 0", busy); end
    checks++;
    assert (full === 1'b0 && tx_done === 1'b0) else begin errors++; $error("FAIL rst_flags got %b%b exp 00", full, tx_done); end
    for (int i = 0; i < 3; i++) step(i[0], 8'h77);
    #2 rst = 1'b1;
    for (int i = 0; i < 70; i++) step(1'b0, 8'h00);
    for (int i = 0; i < 900; i++) step($urandom_range(0, 19) == 0, 8'($urandom));
    for (int i = 0; i < 5 * F; i++) step(1'b0, 8'h00);
    for (int i = 0; i < 3 * F; i++) step($urandom_range(0, 1) == 1, 8'($urandom));
    for (int i = 0; i < 5 * F; i++) step(1'b0, 8'h00);
    cap = 1'b1;
    step(1'b1, 8'h03);
    for (int i = 0; i < F + 5; i++) step(1'b0, 8'h00);
    cap = 1'b0;
    s = -1;
    for (int i = 0; i < line_q.size(); i++) if (s < 0 && line_q[i] == 1'b0) s = i;
    rx = 8'h00;
    if (s >= 0 && s + 9 * BPS + BPS / 2 < line_q.size())
      for (int b = 0; b < 8; b++) rx[b] = line_q[s + (b + 1) * BPS + BPS / 2];
    checks++;
    assert (rx === 8'h03) else begin errors++; $error("FAIL loopback got %h exp 03", rx); end
    checks++;
    assert (s >= 0 && s + 9 * BPS + BPS / 2 < line_q.size() && line_q[s + 9 * BPS + BPS / 2] === 1'b1)
      else begin errors++; $error("FAIL loopback_stop start_idx %0d exp stop bit 1", s); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
